// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM state encoding and the step-counter width helper.
package mdu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic int step_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    modport master (
        output start, funct, a, b,
        input  busy, done, illegal, hi, lo, rdata
    );

    modport slave (
        input  start, funct, a, b,
        output busy, done, illegal, hi, lo, rdata
    );
endinterface

// File: rtl/mdu_fsm.sv
// Control FSM: IDLE -> CALC (WIDTH steps) -> FIX, plus busy/done/illegal generation.
module mdu_fsm
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   go_i,
    input  logic   bad_i,
    output state_e state_o,
    output logic   busy_o,
    output logic   done_o,
    output logic   illegal_o
);
    localparam int             CW        = step_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = (state_q == ST_FIX);
        illegal_d = (state_q == ST_IDLE) && bad_i;
        unique case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_o   = state_q;
        busy_o    = (state_q != ST_IDLE);
        done_o    = done_q;
        illegal_o = illegal_q;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply, restoring
// divide on magnitudes, sign correction in FIX.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    muldiv_unit_if.slave    bus
);
    state_e             state;
    logic               busy, done, illegal;
    logic               go, bad, idle;
    logic               is_arith, is_legal, is_div_op, signed_op, div_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign idle      = !busy;
    assign is_arith  = (bus.funct == FN_MULT) || (bus.funct == FN_MULTU) ||
                       (bus.funct == FN_DIV)  || (bus.funct == FN_DIVU);
    assign is_legal  = is_arith || (bus.funct == FN_MFHI) || (bus.funct == FN_MTHI) ||
                       (bus.funct == FN_MFLO) || (bus.funct == FN_MTLO);
    assign is_div_op = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
    assign signed_op = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
    assign div_zero  = is_div_op && (bus.b == '0);
    assign abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign go        = bus.start && idle && is_arith;
    assign bad       = bus.start && idle && !is_legal;

    mdu_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .go_i      (go),
        .bad_i     (bad),
        .state_o   (state),
        .busy_o    (busy),
        .done_o    (done),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd_q};
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && bus.funct == FN_MTHI) hi_d = bus.a;
                if (bus.start && bus.funct == FN_MTLO) lo_d = bus.a;
                if (go) begin
                    is_div_d = is_div_op;
                    // Divide by zero keeps the raw dividend so it lands in HI untouched.
                    neg_lo_d = signed_op && !div_zero && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi_d = signed_op && is_div_op && !div_zero && bus.a[WIDTH-1];
                    if (is_div_op) begin
                        acc_d  = {{WIDTH{1'b0}}, (div_zero ? bus.a : abs_a)};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    // Remainder in the upper half, quotient bits shift in at the bottom.
                    if (diff[WIDTH])
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.illegal = illegal;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rdata   = (bus.funct == FN_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected=no done", bus.hi, bus.lo);
            end else begin
                mon_e = sb.pop_front();
                $display("done %s: hi=%h lo=%h", mon_e.name, bus.hi, bus.lo);
                chk({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
            end
        end
    end

    task automatic push(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=1 expected=0 within 200 cycles");
        end
    endtask

    // Drives start for one cycle (cycle 0); returns at the negedge of cycle 1.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        wait_idle();
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        bus.start = 1'b0;
        bus.funct = FN_MFLO;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy",    {31'b0, bus.busy},    '0);
        chk("rst_done",    {31'b0, bus.done},    '0);
        chk("rst_illegal", {31'b0, bus.illegal}, '0);
        chk("rst_hi",      bus.hi,               '0);
        chk("rst_lo",      bus.lo,               '0);
        chk("rst_rdata",   bus.rdata,            '0);
        rst_n = 1'b1;

        // 1: unsigned max*max with exact busy/done timing
        push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), {31'b0, bus.busy}, {31'b0, (k <= 33)});
            chk($sformatf("t1_done_c%0d", k), {31'b0, bus.done}, {31'b0, (k == 34)});
        end

        // 2: signed multiply and divide, issued back-to-back
        push("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(FN_MULT, 32'hFFFF_FFFD, 32'd5);
        push("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        push("div_7dm2", 32'h0000_0001, 32'hFFFF_FFFD);
        issue(FN_DIV, 32'd7, 32'hFFFF_FFFE);
        push("mult_minxmin", 32'h4000_0000, 32'h0000_0000);
        issue(FN_MULT, 32'h8000_0000, 32'h8000_0000);

        // 3: divide by zero and signed overflow
        push("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF);
        issue(FN_DIVU, 32'd7, 32'd0);
        push("div_m7_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        issue(FN_DIV, 32'hFFFF_FFF9, 32'd0);
        push("div_ovf", 32'h0000_0000, 32'h8000_0000);
        issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // 4: mtlo while busy is ignored; mtlo/mthi then read through rdata
        push("multu_3x4", 32'h0000_0000, 32'h0000_000C);
        issue(FN_MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.funct = FN_MTLO;
        bus.a     = 32'h0000_AAAA;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        issue(FN_MTLO, 32'h0000_1234, 32'd0);
        bus.funct = FN_MFLO;
        #1 chk("mtlo_rdata", bus.rdata, 32'h0000_1234);
        issue(FN_MTHI, 32'h0000_5678, 32'd0);
        bus.funct = FN_MFHI;
        #1 chk("mthi_rdata", bus.rdata, 32'h0000_5678);
        bus.funct = FN_MFLO;
        #1 chk("mthi_keeps_lo", bus.rdata, 32'h0000_1234);

        // 5: reset mid-divide abandons the operation
        push("divu_aborted", 32'h0000_0001, 32'h0000_014D);
        issue(FN_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", {31'b0, bus.busy}, '0);
        chk("abort_hi",   bus.hi,            '0);
        chk("abort_lo",   bus.lo,            '0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        push("divu_100d7", 32'd2, 32'd14);
        issue(FN_DIVU, 32'd100, 32'd7);
        wait_idle();

        // 6: unsupported funct pulses illegal and changes nothing else
        issue(6'b100000, 32'h1111_1111, 32'h2222_2222);
        chk("ill_pulse", {31'b0, bus.illegal}, 32'd1);
        chk("ill_busy",  {31'b0, bus.busy},    '0);
        chk("ill_hi",    bus.hi,               32'd2);
        chk("ill_lo",    bus.lo,               32'd14);
        @(negedge clk);
        chk("ill_clear", {31'b0, bus.illegal}, '0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
